stim_serializer: RTL and testbench

STIM_SERIALIZER -- requirements
Module: stim_serializer

---
 rtl/stim_serializer_pkg.sv | 12 +
 rtl/word_fifo.sv | 64 ++++++
 rtl/stim_serializer.sv | 115 +++++++++++
 tb/tb_stim_serializer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stim_serializer_pkg.sv
// rtl/stim_serializer_pkg.sv - shared constants and FSM encoding for the word serializer
package stim_serializer_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - circular word FIFO with occupancy count (DEPTH must be a power of two)
module word_fifo
    import stim_serializer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/stim_serializer.sv
// rtl/stim_serializer.sv - buffers parallel words and shifts them out MSB first as a bit stream
module stim_serializer
    import stim_serializer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             in_bit,
    output logic             bit_valid,
    output logic             word_start,
    output logic             busy
);

    localparam int CNTW = $clog2(WIDTH);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

    state_t                     state;
    state_t                     state_nxt;
    logic [WIDTH-1:0]           shreg;
    logic [WIDTH-1:0]           shreg_nxt;
    logic [CNTW-1:0]            bit_cnt;
    logic [CNTW-1:0]            bit_cnt_nxt;
    logic                       in_bit_nxt;
    logic                       bit_valid_nxt;
    logic                       word_start_nxt;
    logic                       load;
    logic                       pop;
    logic                       push;
    logic [WIDTH-1:0]           fifo_rdata;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;

    assign din_ready = !fifo_full;
    assign push      = din_valid && din_ready;
    assign busy      = (state == ST_SHIFT) || (fifo_count != '0);

    word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (din),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // The in_bit flop always mirrors shreg[WIDTH-1] while shifting, so the
    // next bit to present is shreg[WIDTH-2] (or the new word's MSB on a load).
    always_comb begin
        state_nxt      = state;
        shreg_nxt      = shreg;
        bit_cnt_nxt    = bit_cnt;
        in_bit_nxt     = 1'b0;
        bit_valid_nxt  = 1'b0;
        word_start_nxt = 1'b0;
        load           = 1'b0;
        pop            = 1'b0;

        if (state == ST_IDLE) begin
            load = !fifo_empty;
        end else if (bit_cnt != CNT_LAST) begin
            shreg_nxt     = shreg << 1;
            bit_cnt_nxt   = bit_cnt + CNT_ONE;
            in_bit_nxt    = shreg[WIDTH-2];
            bit_valid_nxt = 1'b1;
        end else if (!fifo_empty) begin
            load = 1'b1;
        end else begin
            state_nxt   = ST_IDLE;
            shreg_nxt   = '0;
            bit_cnt_nxt = '0;
        end

        if (load) begin
            pop            = 1'b1;
            state_nxt      = ST_SHIFT;
            shreg_nxt      = fifo_rdata;
            bit_cnt_nxt    = '0;
            in_bit_nxt     = fifo_rdata[WIDTH-1];
            bit_valid_nxt  = 1'b1;
            word_start_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            in_bit     <= 1'b0;
            bit_valid  <= 1'b0;
            word_start <= 1'b0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            bit_cnt    <= bit_cnt_nxt;
            in_bit     <= in_bit_nxt;
            bit_valid  <= bit_valid_nxt;
            word_start <= word_start_nxt;
        end
    end

endmodule

// File: tb/tb_stim_serializer.sv
// tb/tb_stim_serializer.sv - self-checking bench for stim_serializer
`timescale 1ns/1ps
module tb_stim_serializer;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic         in_bit;
    logic         bit_valid;
    logic         word_start;
    logic         busy;

    always #5 clk = ~clk;

    stim_serializer #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .in_bit     (in_bit),
        .bit_valid  (bit_valid),
        .word_start (word_start),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    // Reference model: every accepted word becomes WIDTH expected bits, MSB first.
    typedef struct packed {
        logic b;
        logic s;
    } sbit_t;

    sbit_t exp_q[$];
    sbit_t sb_e;
    logic  sb_en = 1'b0;

    function automatic void model_push(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) begin
            exp_q.push_back({w[i], (i == W - 1)});
        end
    endfunction

    always @(negedge clk) begin
        if (sb_en && rst_n) begin
            if (bit_valid) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_bit", 32'd1, 32'd0);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("sb_in_bit", 32'(in_bit), 32'(sb_e.b));
                    check("sb_word_start", 32'(word_start), 32'(sb_e.s));
                end
            end else begin
                check("sb_idle_outputs", 32'({in_bit, word_start}), 32'd0);
            end
        end
    end

    // Downstream mealy "101" detector fed by in_bit.
    typedef enum logic [1:0] {M_S0, M_S1, M_S2} mstate_t;
    mstate_t mst;
    logic    mout;

    always @(posedge clk) begin
        if (!rst_n) begin
            mst <= M_S0;
        end else begin
            case (mst)
                M_S0:    mst <= in_bit ? M_S1 : M_S0;
                M_S1:    mst <= in_bit ? M_S1 : M_S2;
                default: mst <= in_bit ? M_S1 : M_S0;
            endcase
        end
    end
    assign mout = (mst == M_S2) && in_bit;

    task automatic wait_idle(input string name);
        int guard = 0;
        while (busy !== 1'b0 || bit_valid !== 1'b0) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                check(name, 32'(busy), 32'd0);
                return;
            end
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        int guard = 0;
        din       = w;
        din_valid = 1'b1;
        while (din_ready !== 1'b1) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                check("push_timeout", 32'd0, 32'd1);
                din_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        model_push(w);
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] word;
        logic [W-1:0] serial;
    } vec_t;

    vec_t         vecs[4];
    logic [W-1:0] got_word;
    logic [23:0]  b2b_pat;
    logic [W-1:0] full_words[6];
    int           occ;
    int           pushed;
    int           vcount;
    logic         exp_ready;
    logic         do_push;
    logic         do_pop;
    logic         acc;

    initial begin
        vecs[0] = '{word: 8'hB4, serial: 8'b1011_0100};
        vecs[1] = '{word: 8'h01, serial: 8'b0000_0001};
        vecs[2] = '{word: 8'h80, serial: 8'b1000_0000};
        vecs[3] = '{word: 8'h3C, serial: 8'b0011_1100};
        full_words[0] = 8'h11;
        full_words[1] = 8'h22;
        full_words[2] = 8'h33;
        full_words[3] = 8'h44;
        full_words[4] = 8'h55;
        full_words[5] = 8'h66;
        b2b_pat = 24'hFF00A5;

        // Reset, with din_valid held to prove nothing is accepted meanwhile.
        rst_n     = 1'b0;
        din_valid = 1'b1;
        din       = 8'h5A;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_bit", 32'(in_bit), 32'd0);
        check("rst_bit_valid", 32'(bit_valid), 32'd0);
        check("rst_word_start", 32'(word_start), 32'd0);
        check("rst_din_ready", 32'(din_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        din_valid = 1'b0;
        rst_n     = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_no_push_busy", 32'(busy), 32'd0);
        check("rst_no_push_valid", 32'(bit_valid), 32'd0);
        sb_en = 1'b1;

        // Single words into an idle block: latency, framing, bit order.
        for (int v = 0; v < 4; v++) begin
            wait_idle("tbl_idle_timeout");
            push_word(vecs[v].word);
            check("tbl_latency_gap", 32'(bit_valid), 32'd0);
            for (int i = 0; i < W; i++) begin
                @(negedge clk);
                check("tbl_bit_valid", 32'(bit_valid), 32'd1);
                check("tbl_word_start", 32'(word_start), 32'(i == 0));
                got_word[W-1-i] = in_bit;
            end
            @(negedge clk);
            check("tbl_after_valid", 32'(bit_valid), 32'd0);
            check("tbl_after_in_bit", 32'(in_bit), 32'd0);
            check("tbl_serial", 32'(got_word), 32'(vecs[v].serial));
        end

        // Back-to-back words must stream with no bubbles.
        wait_idle("b2b_idle_timeout");
        fork
            begin
                push_word(8'hFF);
                push_word(8'h00);
                push_word(8'hA5);
            end
            begin
                @(posedge clk);
                @(negedge clk);
                check("b2b_gap_before", 32'(bit_valid), 32'd0);
                for (int i = 0; i < 24; i++) begin
                    @(negedge clk);
                    check("b2b_bit_valid", 32'(bit_valid), 32'd1);
                    check("b2b_word_start", 32'(word_start), 32'((i % W) == 0));
                    check("b2b_in_bit", 32'(in_bit), 32'(b2b_pat[23-i]));
                end
                @(negedge clk);
                check("b2b_gap_after", 32'(bit_valid), 32'd0);
            end
        join

        // din_valid held high: occupancy model predicts din_ready each cycle.
        // Words are popped on the edge after the first push and then every W edges.
        wait_idle("full_idle_timeout");
        occ    = 0;
        pushed = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            exp_ready = (occ < D);
            check("full_din_ready", 32'(din_ready), 32'(exp_ready));
            din_valid = (pushed < 6);
            din       = full_words[pushed % 6];
            do_push   = (pushed < 6) && exp_ready;
            do_pop    = (occ > 0) && (cyc >= 1) && (((cyc - 1) % W) == 0);
            @(posedge clk);
            if (do_push) begin
                model_push(din);
                pushed++;
            end
            occ = occ + int'(do_push) - int'(do_pop);
            @(negedge clk);
        end
        din_valid = 1'b0;
        wait_idle("full_drain_timeout");
        check("full_pushed", 32'(pushed), 32'd6);
        check("full_all_emitted", 32'(exp_q.size()), 32'd0);

        // Reset mid-word with two words queued behind it.
        wait_idle("rstmid_idle_timeout");
        fork
            begin
                push_word(8'hC3);
                push_word(8'h3C);
                push_word(8'h99);
            end
            begin
                @(posedge clk);
                repeat (5) @(negedge clk);
            end
        join
        check("rstmid_bit3_valid", 32'(bit_valid), 32'd1);
        check("rstmid_bit3_value", 32'(in_bit), 32'd0);
        check("rstmid_bit3_start", 32'(word_start), 32'd0);
        sb_en = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        check("rstmid_in_bit", 32'(in_bit), 32'd0);
        check("rstmid_bit_valid", 32'(bit_valid), 32'd0);
        check("rstmid_word_start", 32'(word_start), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_din_ready", 32'(din_ready), 32'd1);
        rst_n  = 1'b1;
        sb_en  = 1'b1;
        vcount = 0;
        repeat (30) begin
            @(negedge clk);
            if (bit_valid) vcount++;
        end
        check("rstmid_flushed", 32'(vcount), 32'd0);
        push_word(8'h5A);
        wait_idle("rstmid_resume_timeout");
        check("rstmid_resume_emitted", 32'(exp_q.size()), 32'd0);

        // All-zero word keeps the downstream detector in its reset state.
        repeat (3) @(negedge clk);
        check("mealy_start_s0", 32'(mst), 32'(M_S0));
        push_word(8'h00);
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bit_valid) vcount++;
            check("mealy_state_s0", 32'(mst), 32'(M_S0));
            check("mealy_out_low", 32'(mout), 32'd0);
        end
        check("mealy_word_seen", 32'(vcount), 32'(W));

        // Random traffic against the scoreboard.
        wait_idle("rand_idle_timeout");
        for (int cyc = 0; cyc < 300; cyc++) begin
            din_valid = ($urandom_range(0, 1) == 1);
            din       = W'($urandom);
            acc       = din_valid && din_ready;
            @(posedge clk);
            if (acc) model_push(din);
            @(negedge clk);
        end
        din_valid = 1'b0;
        wait_idle("rand_drain_timeout");
        check("rand_all_emitted", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
